powlib_modcntr: RTL and testbench
=================================

POWLIB_MODCNTR -- requirements
Module: powlib_modcntr

Interface
REQ-001 SHALL have parameter W, default 8: counter width in bits, W >= 2.
REQ-002 SHALL have parameter INIT, default 0: value taken on rst and clr.
REQ-003 SHALL have parameter LO, default 0: lower bound of count range.
REQ-004 SHALL have parameter HI, default 2**W-1: upper bound of count range.
REQ-005 SHALL have parameter SAT, default 0: 0 = wrap mode, 1 = saturate mode.
REQ-006 SHALL have parameter ELD, default 1: 1 enables load; 0 ignores ld and nval.
REQ-007 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-008 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have adv  input  1  advance the counter by step this cycle.
REQ-010 SHALL have dir  input  1  direction for adv: 0 = up, 1 = down.
REQ-011 SHALL have step  input  W  unsigned increment/decrement magnitude.
REQ-012 SHALL have ld  input  1  load nval this cycle.
REQ-013 SHALL have nval  input  W  load value.
REQ-014 SHALL have clr  input  1  return counter to INIT.
REQ-015 SHALL have cntr  output  W  registered count value.
REQ-016 SHALL have tc  output  1  registered terminal-count pulse, one cycle per boundary event.
REQ-017 SHALL have atmax  output  1  combinational: cntr == HI.
REQ-018 SHALL have atmin  output  1  combinational: cntr == LO.

Function
REQ-019 SHALL enforce at elaboration LO < HI and LO <= INIT <= HI; violation is a fatal elaboration error.
REQ-020 SHALL apply one action per cycle, priority rst > clr > ld (ELD=1 only) > adv > hold.
REQ-021 SHALL on clr set cntr = INIT, tc = 0 next cycle.
REQ-022 SHALL on ld set cntr = nval verbatim (no clamping), tc = 0 next cycle.
REQ-023 SHALL compute up sum = cntr + step and down difference = cntr - step in W+1 bits, no truncation before comparison.
REQ-024 SHALL on adv, dir=0: if sum <= HI then cntr = sum, tc = 0; else boundary event.
REQ-025 SHALL on adv, dir=1: if cntr >= step and cntr - step >= LO then cntr = cntr - step, tc = 0; else boundary event.
REQ-026 SHALL on up boundary event set cntr = LO (SAT=0) or HI (SAT=1), and tc = 1, next cycle.
REQ-027 SHALL on down boundary event set cntr = HI (SAT=0) or LO (SAT=1), and tc = 1, next cycle.
REQ-028 SHALL in SAT=1 raise tc on every adv that hits the boundary, including repeated adv while already at HI (up) or LO (down) with step > 0.
REQ-029 SHALL treat adv with step = 0 as hold: cntr unchanged, tc = 0.
REQ-030 SHALL with no action (hold) keep cntr unchanged and drive tc = 0; tc never lasts more than one cycle per event.
REQ-031 SHALL have single-cycle latency: action sampled at edge N is visible on cntr/tc after edge N.
REQ-032 SHALL with a loaded out-of-range value apply REQ-024/025 unchanged (e.g. cntr > HI, up adv -> boundary event).

Reset
REQ-033 SHALL on rst high at a rising edge set cntr = INIT, tc = 0, overriding all other inputs.
REQ-034 SHALL abandon any in-progress sequence on rst; first post-reset adv counts from INIT.

Verification
REQ-035 SHALL cover: W=8, LO=2, HI=5, INIT=2, SAT=0, step=1, dir=0, adv held 5 cycles -> cntr 3,4,5,2,3; tc=1 only in cycle cntr returns to 2.
REQ-036 SHALL cover: same, SAT=1, adv up 5 cycles -> cntr 3,4,5,5,5; tc=1 on 4th and 5th cycles; atmax=1 from 3rd cycle.
REQ-037 SHALL cover: SAT=0, cntr=3, dir=1, step=2, adv -> cntr=5 (wrap to HI), tc=1; step=3 from cntr=2 (cntr<step path) -> cntr=5, tc=1.
REQ-038 SHALL cover: W=8, LO=0, HI=255, cntr=250, step=10, up adv -> no 8-bit aliasing, cntr=0, tc=1.
REQ-039 SHALL cover: clr, ld(nval=4) and adv asserted together -> cntr=INIT; ld+adv -> cntr=4, tc=0; ELD=0 ld+adv -> adv applied.
REQ-040 SHALL cover: rst asserted mid-count with adv, ld, clr high -> cntr=INIT, tc=0 next cycle; counting resumes from INIT after rst drops.

Source files
------------

// File: rtl/powlib_modcntr.sv
// Bounded up/down modulo counter with load, clear, wrap or saturate at [LO, HI].
// Emits a one-cycle terminal-count pulse each time an advance crosses a bound.
module powlib_modcntr #(
    parameter int W    = 8,
    parameter int INIT = 0,
    parameter int LO   = 0,
    parameter int HI   = (1 << W) - 1,
    parameter bit SAT  = 1'b0,
    parameter bit ELD  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         dir,
    input  logic [W-1:0] step,
    input  logic         ld,
    input  logic [W-1:0] nval,
    input  logic         clr,
    output logic [W-1:0] cntr,
    output logic         tc,
    output logic         atmax,
    output logic         atmin
);

    if (!(W >= 2 && LO < HI && LO <= INIT && INIT <= HI)) begin : g_bad_params
        $fatal(1, "powlib_modcntr: need W >= 2, LO < HI and LO <= INIT <= HI");
    end

    localparam logic [W:0]   LO_X   = (W+1)'(LO);
    localparam logic [W:0]   HI_X   = (W+1)'(HI);
    localparam logic [W-1:0] LO_V   = W'(LO);
    localparam logic [W-1:0] HI_V   = W'(HI);
    localparam logic [W-1:0] INIT_V = W'(INIT);

    logic [W-1:0] cntr_q, cntr_d;
    logic         tc_q, tc_d;
    logic [W:0]   sum, diff;

    // One extra bit so an up-step past 2**W-1 is seen as an overflow, not an alias.
    assign sum  = {1'b0, cntr_q} + {1'b0, step};
    assign diff = {1'b0, cntr_q} - {1'b0, step};

    always_comb begin
        cntr_d = cntr_q;
        tc_d   = 1'b0;
        if (clr) begin
            cntr_d = INIT_V;
        end else if (ELD && ld) begin
            cntr_d = nval;
        end else if (adv && step != '0) begin
            if (!dir) begin
                if (sum <= HI_X) begin
                    cntr_d = sum[W-1:0];
                end else begin
                    cntr_d = SAT ? HI_V : LO_V;
                    tc_d   = 1'b1;
                end
            end else begin
                // diff is only meaningful once cntr >= step rules out the borrow.
                if (cntr_q >= step && diff >= LO_X) begin
                    cntr_d = diff[W-1:0];
                end else begin
                    cntr_d = SAT ? LO_V : HI_V;
                    tc_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntr_q <= INIT_V;
            tc_q   <= 1'b0;
        end else begin
            cntr_q <= cntr_d;
            tc_q   <= tc_d;
        end
    end

    assign cntr  = cntr_q;
    assign tc    = tc_q;
    assign atmax = (cntr_q == HI_V);
    assign atmin = (cntr_q == LO_V);

endmodule

// File: tb/tb_powlib_modcntr.sv
// Bench for powlib_modcntr: four configurations share one stimulus stream and
// are checked each cycle against a behavioural model through an expected queue.
module tb_powlib_modcntr;

    localparam int ND = 4;

    // Per-instance configuration: wrap [2,5], saturate [2,5], full 8-bit wrap, no-load wrap [2,5].
    int lo_p   [ND] = '{2, 2, 0, 2};
    int hi_p   [ND] = '{5, 5, 255, 5};
    int init_p [ND] = '{2, 2, 0, 2};
    int sat_p  [ND] = '{0, 1, 0, 0};
    int eld_p  [ND] = '{1, 1, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adv = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] step = 8'd0;
    logic       ld = 1'b0;
    logic [7:0] nval = 8'd0;
    logic       clr = 1'b0;

    logic [7:0] cntr_w  [ND];
    logic       tc_w    [ND];
    logic       atmax_w [ND];
    logic       atmin_w [ND];

    int m_cntr [ND];
    logic [8*ND-1:0] exp_q[$];
    logic [ND-1:0]   exp_tc_q[$];
    string           tag_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    powlib_modcntr #(.W(8), .INIT(2), .LO(2), .HI(5), .SAT(1'b0), .ELD(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .step(step), .ld(ld), .nval(nval), .clr(clr),
        .cntr(cntr_w[0]), .tc(tc_w[0]), .atmax(atmax_w[0]), .atmin(atmin_w[0]));
    powlib_modcntr #(.W(8), .INIT(2), .LO(2), .HI(5), .SAT(1'b1), .ELD(1'b1)) u_sat (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .step(step), .ld(ld), .nval(nval), .clr(clr),
        .cntr(cntr_w[1]), .tc(tc_w[1]), .atmax(atmax_w[1]), .atmin(atmin_w[1]));
    powlib_modcntr #(.W(8)) u_full (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .step(step), .ld(ld), .nval(nval), .clr(clr),
        .cntr(cntr_w[2]), .tc(tc_w[2]), .atmax(atmax_w[2]), .atmin(atmin_w[2]));
    powlib_modcntr #(.W(8), .INIT(2), .LO(2), .HI(5), .SAT(1'b0), .ELD(1'b0)) u_nold (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .step(step), .ld(ld), .nval(nval), .clr(clr),
        .cntr(cntr_w[3]), .tc(tc_w[3]), .atmax(atmax_w[3]), .atmin(atmin_w[3]));

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_step(input int k, output int nc, output bit t);
        int c;
        int s;
        c  = m_cntr[k];
        s  = int'(step);
        nc = c;
        t  = 1'b0;
        if (rst || clr) begin
            nc = init_p[k];
        end else if (ld && eld_p[k] != 0) begin
            nc = int'(nval);
        end else if (adv && s != 0) begin
            if (!dir) begin
                if (c + s <= hi_p[k]) nc = c + s;
                else begin
                    nc = (sat_p[k] != 0) ? hi_p[k] : lo_p[k];
                    t  = 1'b1;
                end
            end else begin
                if (c >= s && c - s >= lo_p[k]) nc = c - s;
                else begin
                    nc = (sat_p[k] != 0) ? lo_p[k] : hi_p[k];
                    t  = 1'b1;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input string tag, input bit r, input bit c, input bit l, input int nv,
                       input bit a, input bit d, input int s);
        logic [8*ND-1:0] e;
        logic [ND-1:0]   et;
        int nc;
        bit t;
        @(negedge clk);
        rst  = r;
        clr  = c;
        ld   = l;
        nval = 8'(nv);
        adv  = a;
        dir  = d;
        step = 8'(s);
        for (int k = 0; k < ND; k++) begin
            model_step(k, nc, t);
            m_cntr[k]   = nc;
            e[k*8 +: 8] = 8'(nc);
            et[k]       = t;
        end
        exp_q.push_back(e);
        exp_tc_q.push_back(et);
        tag_q.push_back(tag);
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        logic [8*ND-1:0] e;
        logic [ND-1:0]   et;
        string           tag;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            et  = exp_tc_q.pop_front();
            tag = tag_q.pop_front();
            for (int k = 0; k < ND; k++) begin
                check($sformatf("%s/d%0d/cntr", tag, k), int'(cntr_w[k]), int'(e[k*8 +: 8]));
                check($sformatf("%s/d%0d/tc", tag, k), int'(tc_w[k]), int'(et[k]));
                check($sformatf("%s/d%0d/atmax", tag, k), int'(atmax_w[k]),
                      int'(int'(e[k*8 +: 8]) == hi_p[k]));
                check($sformatf("%s/d%0d/atmin", tag, k), int'(atmin_w[k]),
                      int'(int'(e[k*8 +: 8]) == lo_p[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < ND; k++) m_cntr[k] = 0;

        cyc("reset", 1, 0, 0, 0, 0, 0, 0);
        cyc("reset", 1, 0, 0, 0, 0, 0, 0);

        // Up by 1 for five cycles: wrap 3,4,5,2,3; saturate 3,4,5,5,5.
        for (int i = 0; i < 5; i++) cyc("up5", 0, 0, 0, 0, 1, 0, 1);
        cyc("hold", 0, 0, 0, 0, 0, 0, 0);

        // Down wraps: 3-2 falls below LO, 2-3 borrows.
        cyc("ld3", 0, 0, 1, 3, 0, 0, 0);
        cyc("dn2", 0, 0, 0, 0, 1, 1, 2);
        cyc("ld2", 0, 0, 1, 2, 0, 0, 0);
        cyc("dn3", 0, 0, 0, 0, 1, 1, 3);

        // 250 + 10 must overflow, not alias to 4.
        cyc("ld250", 0, 0, 1, 250, 0, 0, 0);
        cyc("up10", 0, 0, 0, 0, 1, 0, 10);

        // Priority among clr, ld and adv.
        cyc("clr_ld_adv", 0, 1, 1, 4, 1, 0, 1);
        cyc("ld_adv", 0, 0, 1, 4, 1, 0, 1);
        cyc("step0", 0, 0, 0, 0, 1, 0, 0);
        cyc("step0dn", 0, 0, 0, 0, 1, 1, 0);

        // Saturate repeatedly at LO and HI.
        for (int i = 0; i < 4; i++) cyc("dnsat", 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) cyc("upsat", 0, 0, 0, 0, 1, 0, 2);

        // Reset mid-count wins over everything, counting resumes from INIT.
        cyc("midcnt", 0, 0, 0, 0, 1, 0, 1);
        cyc("rst_all", 1, 1, 1, 4, 1, 0, 1);
        cyc("post_rst", 0, 0, 0, 0, 1, 0, 1);
        cyc("post_rst", 0, 0, 0, 0, 1, 0, 1);

        // Out-of-range loaded values then advance.
        cyc("ld_oor", 0, 0, 1, 9, 0, 0, 0);
        cyc("oor_up", 0, 0, 0, 0, 1, 0, 1);
        cyc("ld_oor", 0, 0, 1, 9, 0, 0, 0);
        cyc("oor_dn", 0, 0, 0, 0, 1, 1, 1);

        for (int i = 0; i < 300; i++) begin
            int nv;
            nv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
            cyc("rand", int'($urandom_range(0, 39) == 0), int'($urandom_range(0, 19) == 0),
                int'($urandom_range(0, 7) == 0), nv, int'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3)));
        end

        cyc("idle", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
